imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single-port instruction BRAM between two requesters: the fetch stage (instruction reads) and the program loader/debug port (reads and writes, e.g. UART boot loading).
- Pipelined request/grant front end with registered memory drive; read data returns tagged to the requester that issued it.
- Sits between the fetch stage / loader and the instruction BRAM primitive.

Parameters:
- DEPTH, 32000, memory size in 32-bit words.
- MEM_AW, 15, word-address width driven to memory; must satisfy 2^MEM_AW >= DEPTH.
- MAX_WAIT, 4, consecutive denied cycles after which the loader takes priority over fetch (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_req  input  1  fetch read request.
- if_addr  input  32  fetch byte address.
- if_gnt  output  1  fetch request accepted this cycle (combinational).
- if_rvalid  output  1  fetch read data valid.
- if_rdata  output  32  fetch read data.
- ld_req  input  1  loader request.
- ld_we  input  1  loader write (1) / read (0).
- ld_addr  input  32  loader byte address.
- ld_wdata  input  32  loader write data.
- ld_gnt  output  1  loader request accepted this cycle (combinational).
- ld_rvalid  output  1  loader read data valid.
- ld_rdata  output  32  loader read data.
- mem_en  output  1  memory access strobe (registered).
- mem_we  output  1  memory write enable (registered).
- mem_addr  output  MEM_AW  word address = byte address >> 2 (registered).
- mem_wdata  output  32  memory write data (registered).
- mem_rdata  input  32  memory read data, valid the cycle after mem_en && !mem_we.
- addr_err  output  1  one-cycle pulse when an accepted request is misaligned or out of range (registered).

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs 0; starvation counter 0; in-flight pipeline cleared. Read data issued before reset never produces rvalid.
- Arbitration, evaluated every cycle (combinational on req and registered state):
  - Only one requester asserting: it is granted.
  - Both asserting: fetch is granted, unless the starvation counter == MAX_WAIT, in which case the loader is granted.
  - At most one gnt is high per cycle. A request is accepted exactly when req && gnt.
- Starvation counter:
  - Increments, saturating at MAX_WAIT, each cycle ld_req is high and ld_gnt is low.
  - Clears to 0 on ld_gnt or when ld_req is low.
- Pipeline: one new access may be accepted every cycle; no back-pressure.
  - Stage 1 (cycle N+1 after accept in N): mem_en/mem_we/mem_addr/mem_wdata are driven from the registered request.
  - Stage 2 (N+2): mem_rdata is routed to the owner's rdata and its rvalid pulses high for 1 cycle.
  - Read latency is therefore 2 cycles from accept to rvalid. Responses return in acceptance order.
- Writes: loader only (fetch is read-only). A write produces no rvalid.
- rdata holds its last value when rvalid is low. The unselected requester's rdata is unchanged.
- Address checks at accept:
  - Misaligned (addr[1:0] != 0) or word index >= DEPTH → request is still granted, but mem_en stays 0 in stage 1 and addr_err pulses in stage 1.
  - A read in this case returns rvalid with rdata = 0 at N+2. A write in this case is dropped.
- Idle cycles: mem_en = 0; mem_addr/mem_wdata hold their previous values.

Test Plan:
- Reset, then fetch-only reads of 0x0, 0x4, 0x8 on consecutive cycles → if_gnt=1 each cycle; mem_addr = 0, 1, 2 at N+1..N+3; if_rvalid at N+2..N+4 with the words preloaded in the memory model.
- Loader writes 0xDEADBEEF to 0x100, then reads 0x100 → mem_we=1 with mem_addr=0x40; the read returns ld_rdata=0xDEADBEEF with ld_rvalid 2 cycles after its accept; no ld_rvalid for the write.
- Both requesters held high continuously, MAX_WAIT=4 → fetch granted 4 cycles, loader granted on the 5th, then fetch again; pattern repeats every 5 cycles.
- Fetch read 0x2 (misaligned) and loader read 0x1F400 (word 32000, out of range) → each is granted; addr_err pulses; mem_en=0; rvalid with rdata=0 to the correct owner.
- Interleaved fetch read then loader read on adjacent cycles → if_rvalid then ld_rvalid on adjacent cycles, each with the correct data; the other port's rdata is unchanged.
- Accept a fetch read, then assert rst_n low at N+1 → all outputs go to 0 immediately; after release, no if_rvalid appears.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bundle between the fetch stage, the loader/debug port, the instruction BRAM and the arbiter.
// The arbiter takes the slave side; the requester/memory environment takes the master side.
interface imem_arbiter_if #(
  parameter int MEM_AW = 15
);
  // fetch requester
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  // loader / debug requester
  logic              ld_req;
  logic              ld_we;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [31:0]       ld_rdata;
  // memory side
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              addr_err;

  modport slave (
    input  if_req, if_addr,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output addr_err
  );

  modport master (
    output if_req, if_addr,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  addr_err
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-requester arbiter for the single-port instruction BRAM: fetch has priority unless the loader
// has been denied MAX_WAIT cycles in a row. Accept -> registered memory drive -> tagged read return (2 cycles).
module imem_arbiter #(
  parameter int DEPTH    = 32000,
  parameter int MEM_AW   = 15,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_arbiter_if.slave bus
);

  localparam int CW = 4;

  // Arbitration and accept-side decode
  logic [CW-1:0] wait_cnt;
  logic          ld_pri;
  logic          if_gnt_c;
  logic          ld_gnt_c;
  logic          acc;
  logic          acc_we;
  logic          acc_err;
  logic          acc_ok;
  logic [31:0]   acc_addr;
  logic [29:0]   acc_word;

  // Stage 1: registered memory drive plus bookkeeping for the return path
  logic              mem_en_q;
  logic              mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              addr_err_q;
  logic              s1_rd;
  logic              s1_ld;
  logic              s1_err;

  // Stage 2: response routing
  logic          if_rvalid_q;
  logic          ld_rvalid_q;
  logic          s2_err;
  logic [31:0]   rsp_data;
  logic [31:0]   if_rdata_q;
  logic [31:0]   ld_rdata_q;

  always_comb begin
    ld_pri   = (wait_cnt == CW'(MAX_WAIT));
    if_gnt_c = bus.if_req && !(bus.ld_req && ld_pri);
    ld_gnt_c = bus.ld_req && !if_gnt_c;
    acc      = if_gnt_c || ld_gnt_c;
    acc_we   = ld_gnt_c && bus.ld_we;
    acc_addr = ld_gnt_c ? bus.ld_addr : bus.if_addr;
    acc_word = acc_addr[31:2];
    acc_err  = (acc_addr[1:0] != 2'b00) || (acc_word >= 30'(DEPTH));
    acc_ok   = acc && !acc_err;
  end

  // Counts consecutive loader denials; reaching MAX_WAIT flips priority for one grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!bus.ld_req || ld_gnt_c) begin
      wait_cnt <= '0;
    end else if (!ld_pri) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      addr_err_q  <= 1'b0;
      s1_rd       <= 1'b0;
      s1_ld       <= 1'b0;
      s1_err      <= 1'b0;
    end else begin
      mem_en_q   <= acc_ok;
      mem_we_q   <= acc_ok && acc_we;
      addr_err_q <= acc && acc_err;
      // Bad reads still travel down the pipe so the owner gets a zero response.
      s1_rd      <= acc && !acc_we;
      s1_ld      <= ld_gnt_c;
      s1_err     <= acc_err;
      if (acc_ok) begin
        mem_addr_q <= acc_addr[MEM_AW+1:2];
      end
      if (acc_ok && acc_we) begin
        mem_wdata_q <= bus.ld_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      s2_err      <= 1'b0;
    end else begin
      if_rvalid_q <= s1_rd && !s1_ld;
      ld_rvalid_q <= s1_rd && s1_ld;
      s2_err      <= s1_rd && s1_err;
    end
  end

  // BRAM data is only valid during the rvalid cycle, so it is passed through then and latched for holding.
  always_comb begin
    rsp_data = s2_err ? 32'h0 : bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
    end else begin
      if (if_rvalid_q) begin
        if_rdata_q <= rsp_data;
      end
      if (ld_rvalid_q) begin
        ld_rdata_q <= rsp_data;
      end
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.ld_gnt    = ld_gnt_c;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ld_rvalid = ld_rvalid_q;
  assign bus.if_rdata  = if_rvalid_q ? rsp_data : if_rdata_q;
  assign bus.ld_rdata  = ld_rvalid_q ? rsp_data : ld_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a synchronous single-port BRAM model on the memory side.
module tb_imem_arbiter;

  localparam logic [31:0] W0   = 32'hA0A0_0000;
  localparam logic [31:0] W1   = 32'hA1A1_0001;
  localparam logic [31:0] W2   = 32'hA2A2_0002;
  localparam logic [31:0] WLD  = 32'h1111_0041;
  localparam logic [31:0] WTOP = 32'h7CFF_7CFF;
  localparam logic [31:0] WDB  = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem_model [0:32767];

  always #5 clk = ~clk;

  imem_arbiter_if #(.MEM_AW(15)) bus ();

  imem_arbiter #(
    .DEPTH(32000),
    .MEM_AW(15),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Synchronous read-first BRAM: data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_model[bus.mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0;
    bus.ld_req   = 1'b0;
    bus.ld_we    = 1'b0;
    bus.ld_addr  = 32'h0;
    bus.ld_wdata = 32'h0;
  endtask

  task automatic test_reset();
    logic [115:0] regs;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    regs = {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.addr_err,
            bus.if_rvalid, bus.ld_rvalid, bus.if_rdata, bus.ld_rdata};
    checks++;
    if (regs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", regs);
    end
    checks++;
    if ({bus.if_gnt, bus.ld_gnt} !== 2'b00) begin
      errors++;
      $display("FAIL reset_gnt got %b want 00", {bus.if_gnt, bus.ld_gnt});
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_reads();
    logic [31:0] fw [0:2];
    logic        exp_en;
    logic        exp_rv;
    fw = '{W0, W1, W2};
    for (int c = 0; c < 6; c++) begin
      tick();
      bus.if_req  = (c < 3);
      bus.if_addr = (c < 3) ? 32'(c * 4) : 32'h0;
      #1;
      checks++;
      if (bus.if_gnt !== (c < 3)) begin
        errors++;
        $display("FAIL fetch_gnt c%0d got %b want %b", c, bus.if_gnt, (c < 3));
      end
      exp_en = (c >= 1) && (c <= 3);
      checks++;
      if (bus.mem_en !== exp_en) begin
        errors++;
        $display("FAIL fetch_mem_en c%0d got %b want %b", c, bus.mem_en, exp_en);
      end
      if (exp_en) begin
        checks++;
        if (bus.mem_addr !== 15'(c - 1)) begin
          errors++;
          $display("FAIL fetch_mem_addr c%0d got %h want %h", c, bus.mem_addr, 15'(c - 1));
        end
      end
      exp_rv = (c >= 2) && (c <= 4);
      checks++;
      if (bus.if_rvalid !== exp_rv) begin
        errors++;
        $display("FAIL fetch_rvalid c%0d got %b want %b", c, bus.if_rvalid, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if (bus.if_rdata !== fw[c-2]) begin
          errors++;
          $display("FAIL fetch_rdata c%0d got %h want %h", c, bus.if_rdata, fw[c-2]);
        end
      end
    end
    checks++;
    if (bus.if_rdata !== W2 || bus.ld_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_hold got %h/%b want %h/0", bus.if_rdata, bus.ld_rvalid, W2);
    end
  endtask

  task automatic test_loader_write_read();
    tick();
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h100; bus.ld_wdata = WDB;
    #1;
    checks++;
    if ({bus.ld_gnt, bus.if_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL ld_wr_gnt got %b want 10", {bus.ld_gnt, bus.if_gnt});
    end
    tick();
    bus.ld_we = 1'b0;
    #1;
    checks++;
    if (bus.ld_gnt !== 1'b1) begin
      errors++;
      $display("FAIL ld_rd_gnt got %b want 1", bus.ld_gnt);
    end
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 15'h40, WDB}) begin
      errors++;
      $display("FAIL ld_write_drive got en=%b we=%b a=%h d=%h want 1 1 0040 %h",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, WDB);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 15'h40}) begin
      errors++;
      $display("FAIL ld_read_drive got en=%b we=%b a=%h want 1 0 0040", bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    checks++;
    if (bus.ld_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL ld_write_no_rvalid got %b want 0", bus.ld_rvalid);
    end
    tick();
    #1;
    checks++;
    if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== WDB) begin
      errors++;
      $display("FAIL ld_read_data got %b/%h want 1/%h", bus.ld_rvalid, bus.ld_rdata, WDB);
    end
    checks++;
    if (bus.if_rdata !== W2 || bus.if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL ld_other_port got %b/%h want 0/%h", bus.if_rvalid, bus.if_rdata, W2);
    end
    tick();
    #1;
    checks++;
    if (bus.ld_rvalid !== 1'b0 || bus.ld_rdata !== WDB) begin
      errors++;
      $display("FAIL ld_hold got %b/%h want 0/%h", bus.ld_rvalid, bus.ld_rdata, WDB);
    end
  endtask

  task automatic test_starvation();
    logic exp_ld;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.if_req = 1'b1; bus.if_addr = 32'h0;
      bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h104;
      #1;
      exp_ld = ((i % 5) == 4);
      checks++;
      if ({bus.if_gnt, bus.ld_gnt} !== {!exp_ld, exp_ld}) begin
        errors++;
        $display("FAIL starve_gnt i%0d got if=%b ld=%b want if=%b ld=%b",
                 i, bus.if_gnt, bus.ld_gnt, !exp_ld, exp_ld);
      end
    end
    tick();
    idle_inputs();
    tick();
    tick();
    #1;
    checks++;
    if (bus.if_rdata !== W0 || bus.ld_rdata !== WLD) begin
      errors++;
      $display("FAIL starve_data got if=%h ld=%h want if=%h ld=%h", bus.if_rdata, bus.ld_rdata, W0, WLD);
    end
  endtask

  task automatic test_addr_errors();
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h2;
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL err_if_gnt got %b want 1", bus.if_gnt);
    end
    tick();
    bus.if_req = 1'b0;
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h1F400;
    #1;
    checks++;
    if ({bus.ld_gnt, bus.addr_err, bus.mem_en} !== 3'b110) begin
      errors++;
      $display("FAIL err_misaligned got gnt=%b err=%b en=%b want 1 1 0", bus.ld_gnt, bus.addr_err, bus.mem_en);
    end
    tick();
    bus.ld_we = 1'b1; bus.ld_wdata = 32'h55;
    #1;
    checks++;
    if ({bus.ld_gnt, bus.addr_err, bus.mem_en} !== 3'b110) begin
      errors++;
      $display("FAIL err_range_rd got gnt=%b err=%b en=%b want 1 1 0", bus.ld_gnt, bus.addr_err, bus.mem_en);
    end
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0 || bus.ld_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL err_if_rsp got %b/%h ld_rvalid=%b want 1/0 0", bus.if_rvalid, bus.if_rdata, bus.ld_rvalid);
    end
    tick();
    bus.ld_we = 1'b0; bus.ld_addr = 32'h1F3FC;
    #1;
    checks++;
    if ({bus.addr_err, bus.mem_en, bus.mem_we} !== 3'b100) begin
      errors++;
      $display("FAIL err_range_wr got err=%b en=%b we=%b want 1 0 0", bus.addr_err, bus.mem_en, bus.mem_we);
    end
    checks++;
    if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== 32'h0 || bus.if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL err_ld_rsp got %b/%h if_rvalid=%b want 1/0 0", bus.ld_rvalid, bus.ld_rdata, bus.if_rvalid);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({bus.addr_err, bus.mem_en, bus.mem_addr} !== {2'b01, 15'h7CFF}) begin
      errors++;
      $display("FAIL err_last_word got err=%b en=%b a=%h want 0 1 7cff", bus.addr_err, bus.mem_en, bus.mem_addr);
    end
    checks++;
    if (bus.ld_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL err_write_dropped got rvalid %b want 0", bus.ld_rvalid);
    end
    tick();
    #1;
    checks++;
    if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== WTOP || bus.if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL err_last_word_rsp got %b/%h if=%h want 1/%h if=0", bus.ld_rvalid, bus.ld_rdata, bus.if_rdata, WTOP);
    end
  endtask

  task automatic test_interleaved();
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL il_if_gnt got %b want 1", bus.if_gnt);
    end
    tick();
    bus.if_req = 1'b0;
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h100;
    #1;
    checks++;
    if ({bus.if_gnt, bus.ld_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL il_ld_gnt got %b want 01", {bus.if_gnt, bus.ld_gnt});
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({bus.if_rvalid, bus.if_rdata, bus.ld_rvalid, bus.ld_rdata} !== {1'b1, W1, 1'b0, WTOP}) begin
      errors++;
      $display("FAIL il_first got if=%b/%h ld=%b/%h want 1/%h 0/%h",
               bus.if_rvalid, bus.if_rdata, bus.ld_rvalid, bus.ld_rdata, W1, WTOP);
    end
    tick();
    #1;
    checks++;
    if ({bus.if_rvalid, bus.if_rdata, bus.ld_rvalid, bus.ld_rdata} !== {1'b0, W1, 1'b1, WDB}) begin
      errors++;
      $display("FAIL il_second got if=%b/%h ld=%b/%h want 0/%h 1/%h",
               bus.if_rvalid, bus.if_rdata, bus.ld_rvalid, bus.ld_rdata, W1, WDB);
    end
  endtask

  task automatic test_reset_inflight();
    logic [115:0] regs;
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rst_if_gnt got %b want 1", bus.if_gnt);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.mem_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_en got %b want 1", bus.mem_en);
    end
    #1;
    rst_n = 1'b0;
    #1;
    regs = {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.addr_err,
            bus.if_rvalid, bus.ld_rvalid, bus.if_rdata, bus.ld_rdata};
    checks++;
    if (regs !== '0) begin
      errors++;
      $display("FAIL rst_async got %h want 0", regs);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h0) begin
        errors++;
        $display("FAIL rst_no_rvalid c%0d got %b/%h want 0/0", c, bus.if_rvalid, bus.if_rdata);
      end
    end
  endtask

  initial begin
    mem_model[0]     = W0;
    mem_model[1]     = W1;
    mem_model[2]     = W2;
    mem_model[15'h41] = WLD;
    mem_model[15'h7CFF] = WTOP;
    test_reset();
    test_fetch_reads();
    test_loader_write_read();
    test_starvation();
    test_addr_errors();
    test_interleaved();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
